// File: rtl/adc_scan_ctrl_if.sv
// Result stream between the ADC scan sequencer and its consumer.
// Valid/ready handshake carrying a 12-bit sample tagged with its channel.
interface adc_scan_ctrl_if;
    logic        res_valid;
    logic        res_ready;
    logic [11:0] res_data;
    logic [3:0]  res_ch;

    modport master (
        output res_valid,
        output res_data,
        output res_ch,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_ch,
        output res_ready
    );
endinterface

// File: rtl/adc_scan_ctrl.sv
// Scan sequencer for one serial multi-channel ADC port.
// Turns a channel mask into command frames plus a trailing flush frame.
module adc_scan_ctrl #(
    parameter int          CLK_DIV   = 4,
    parameter int          CONV_WAIT = 40,
    parameter int          NCH       = 8,
    parameter logic [3:0]  FLUSH_CMD = 4'hB
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic [NCH-1:0] ch_mask,
    output logic           cs,
    output logic           fs,
    output logic           sclk,
    output logic           sdo,
    input  logic           sdi,
    output logic           cstart,
    output logic           busy,
    output logic           scan_done,
    adc_scan_ctrl_if.master res
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_WAIT
    } state_t;

    localparam logic [9:0] HALF  = 10'(CLK_DIV - 1);
    localparam logic [9:0] FULL  = 10'(2 * CLK_DIV - 1);
    localparam logic [9:0] WLAST = 10'(CONV_WAIT - 1);

    state_t           state_q, state_d;
    logic [9:0]       cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [15:0]      cmd_q, cmd_d;
    logic [15:0]      shreg_q, shreg_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [3:0]       ch_q, ch_d;
    logic [3:0]       prev_q, prev_d;
    logic             first_q, first_d;
    logic             flush_q, flush_d;
    logic             cs_q, cs_d;
    logic             fs_q, fs_d;
    logic             sclk_q, sclk_d;
    logic             sdo_q, sdo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic [11:0]      data_q, data_d;
    logic [3:0]       rch_q, rch_d;
    logic [3:0]       nxt_ch;

    function automatic logic [3:0] lowest(input logic [NCH-1:0] m);
        logic [3:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    assign nxt_ch = lowest(mask_q);

    // Next-state and next-output computation; everything leaves through registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        cmd_d   = cmd_q;
        shreg_d = shreg_q;
        mask_d  = mask_q;
        ch_d    = ch_q;
        prev_d  = prev_q;
        first_d = first_q;
        flush_d = flush_q;
        cs_d    = cs_q;
        fs_d    = fs_q;
        sclk_d  = sclk_q;
        sdo_d   = sdo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        data_d  = data_q;
        rch_d   = rch_q;

        if (valid_q && res.res_ready) valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && (|ch_mask)) begin
                    ch_d    = lowest(ch_mask);
                    mask_d  = ch_mask & (ch_mask - NCH'(1));
                    cmd_d   = {lowest(ch_mask), 12'h000};
                    sdo_d   = lowest(ch_mask) >> 3 != 4'd0;
                    first_d = 1'b1;
                    flush_d = 1'b0;
                    busy_d  = 1'b1;
                    cs_d    = 1'b0;
                    fs_d    = 1'b1;
                    sclk_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    fs_d    = 1'b0;
                    sclk_d  = 1'b1;
                    sdo_d   = cmd_q[15];
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q + 10'd1;
                if (cnt_q == HALF) begin
                    shreg_d = {shreg_q[14:0], sdi};
                    sclk_d  = 1'b0;
                end
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    if (bit_q == 4'd15) begin
                        cs_d    = 1'b1;
                        sdo_d   = 1'b0;
                        state_d = S_HOLD;
                    end else begin
                        bit_d  = bit_q + 4'd1;
                        sclk_d = 1'b1;
                        sdo_d  = cmd_q[14];
                        cmd_d  = cmd_q << 1;
                    end
                end
            end
            S_HOLD: begin
                if (!first_q) begin
                    valid_d = 1'b1;
                    data_d  = shreg_q[15:4];
                    rch_d   = prev_q;
                end
                prev_d  = ch_q;
                first_d = 1'b0;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != WLAST) begin
                    cnt_d = cnt_q + 10'd1;
                end else if (!(valid_q && !res.res_ready)) begin
                    cnt_d = '0;
                    if (flush_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cs_d    = 1'b0;
                        fs_d    = 1'b1;
                        state_d = S_SETUP;
                        if (|mask_q) begin
                            ch_d   = nxt_ch;
                            mask_d = mask_q & (mask_q - NCH'(1));
                            cmd_d  = {nxt_ch, 12'h000};
                            sdo_d  = nxt_ch[3];
                        end else begin
                            flush_d = 1'b1;
                            cmd_d   = {FLUSH_CMD, 12'h000};
                            sdo_d   = FLUSH_CMD[3];
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            cs_d    = 1'b1;
            fs_d    = 1'b0;
            sclk_d  = 1'b0;
            sdo_d   = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State and output register bank with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            cmd_q   <= '0;
            shreg_q <= '0;
            mask_q  <= '0;
            ch_q    <= '0;
            prev_q  <= '0;
            first_q <= 1'b0;
            flush_q <= 1'b0;
            cs_q    <= 1'b1;
            fs_q    <= 1'b0;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            rch_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            cmd_q   <= cmd_d;
            shreg_q <= shreg_d;
            mask_q  <= mask_d;
            ch_q    <= ch_d;
            prev_q  <= prev_d;
            first_q <= first_d;
            flush_q <= flush_d;
            cs_q    <= cs_d;
            fs_q    <= fs_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            rch_q   <= rch_d;
        end
    end

    assign cs            = cs_q;
    assign fs            = fs_q;
    assign sclk          = sclk_q;
    assign sdo           = sdo_q;
    assign cstart        = 1'b1;
    assign busy          = busy_q;
    assign scan_done     = done_q;
    assign res.res_valid = valid_q;
    assign res.res_data  = data_q;
    assign res.res_ch    = rch_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: ADC model with one-frame result pipeline,
// command and result scoreboards, directed timing/abort/reset cases.
module tb_adc_scan_ctrl;

    localparam int CLK_DIV   = 4;
    localparam int CONV_WAIT = 40;
    localparam int NCH       = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           sdi = 1'b0;
    logic [NCH-1:0] ch_mask = '0;
    logic           cs, fs, sclk, sdo, cstart, busy, scan_done;

    adc_scan_ctrl_if r();

    adc_scan_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .CONV_WAIT (CONV_WAIT),
        .NCH       (NCH),
        .FLUSH_CMD (4'hB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .ch_mask   (ch_mask),
        .cs        (cs),
        .fs        (fs),
        .sclk      (sclk),
        .sdo       (sdo),
        .sdi       (sdi),
        .cstart    (cstart),
        .busy      (busy),
        .scan_done (scan_done),
        .res       (r)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] fval(input logic [3:0] c);
        return 12'hABC ^ {c, c, c} ^ 12'h222;
    endfunction

    logic [15:0] exp_cmd[$];
    logic [15:0] exp_res[$];
    bit          frame_chk = 1'b1;
    int          done_cnt = 0;

    // ADC model: returns the previous frame's conversion, records the command
    bit          in_frame = 1'b0;
    int          bits = 0;
    logic [15:0] rx, tx, prev;
    bit          prev_ok = 1'b0;
    time         last_rise = 0;

    always @(negedge cs) begin
        in_frame  = 1'b1;
        bits      = 0;
        rx        = '0;
        tx        = prev_ok ? {fval(prev[15:12]), 4'h0} : 16'hDEAD;
        last_rise = 0;
    end

    always @(posedge sclk) begin
        if (in_frame) begin
            if (last_rise != 0 && frame_chk)
                chk("sclk_period", 32'($time - last_rise), 2 * CLK_DIV * 10);
            last_rise = $time;
            if (bits < 16) sdi = tx[15 - bits];
        end
    end

    always @(negedge sclk) begin
        if (in_frame) begin
            rx   = {rx[14:0], sdo};
            bits = bits + 1;
        end
    end

    always @(posedge cs) begin
        logic [15:0] e;
        if (in_frame) begin
            in_frame = 1'b0;
            if (frame_chk) begin
                chk("sclk_pulses", 32'(bits), 16);
                if (exp_cmd.size() == 0) begin
                    chk("cmd_extra", 32'(rx), 32'hFFFF_FFFF);
                end else begin
                    e = exp_cmd.pop_front();
                    chk("cmd", 32'(rx), 32'(e));
                end
            end
            prev    = rx;
            prev_ok = (bits == 16);
        end
    end

    // Result scoreboard: a transfer completes at the next rising edge
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst && r.res_valid === 1'b1 && r.res_ready === 1'b1) begin
            if (exp_res.size() == 0) begin
                chk("res_extra", 32'({r.res_ch, r.res_data}), 32'hFFFF_FFFF);
            end else begin
                e = exp_res.pop_front();
                chk("res", 32'({r.res_ch, r.res_data}), 32'(e));
            end
        end
        if (scan_done === 1'b1) done_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_scan(input logic [NCH-1:0] m);
        for (int c = 0; c < NCH; c++) begin
            if (m[c]) begin
                exp_cmd.push_back({4'(c), 12'h000});
                exp_res.push_back({4'(c), fval(4'(c))});
            end
        end
        exp_cmd.push_back(16'hB000);
    endtask

    task automatic wait_done(input int lim, output int got);
        got = -1;
        for (int k = 1; k <= lim; k++) begin
            tick();
            if (scan_done === 1'b1) begin
                got = k;
                break;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cs"}, 32'(cs), 1);
        chk({tag, "_fs"}, 32'(fs), 0);
        chk({tag, "_sclk"}, 32'(sclk), 0);
        chk({tag, "_sdo"}, 32'(sdo), 0);
        chk({tag, "_cstart"}, 32'(cstart), 1);
        chk({tag, "_valid"}, 32'(r.res_valid), 0);
        chk({tag, "_data"}, 32'(r.res_data), 0);
        chk({tag, "_ch"}, 32'(r.res_ch), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(scan_done), 0);
    endtask

    initial begin
        int got;
        int d0;
        r.res_ready = 1'b1;

        repeat (3) tick();
        chk_reset_vals("rst");
        rst = 1'b0;
        tick();

        // single channel
        ch_mask = 8'h04;
        start   = 1'b1;
        push_scan(8'h04);
        tick();
        start = 1'b0;
        chk("start_cs", 32'(cs), 0);
        chk("start_fs", 32'(fs), 1);
        chk("start_busy", 32'(busy), 1);
        got = -1;
        for (int k = 1; k <= 2000; k++) begin
            if (k == 200) begin
                start   = 1'b1;
                ch_mask = 8'h01;
            end
            if (k == 201) start = 1'b0;
            tick();
            if (scan_done === 1'b1) begin
                got = k;
                break;
            end
        end
        chk("done_cyc_1ch", 32'(got), 346);
        chk("busy_after_1ch", 32'(busy), 0);
        tick();
        chk("res_left_1ch", 32'(exp_res.size()), 0);
        chk("cmd_left_1ch", 32'(exp_cmd.size()), 0);

        // full scan
        repeat (5) tick();
        ch_mask = 8'hFF;
        start   = 1'b1;
        push_scan(8'hFF);
        tick();
        start = 1'b0;
        wait_done(3000, got);
        chk("done_cyc_full", 32'(got), 1557);
        tick();
        chk("res_left_full", 32'(exp_res.size()), 0);
        chk("cmd_left_full", 32'(exp_cmd.size()), 0);

        // backpressure
        repeat (5) tick();
        r.res_ready = 1'b0;
        ch_mask = 8'h03;
        start   = 1'b1;
        push_scan(8'h03);
        tick();
        start = 1'b0;
        got = -1;
        for (int k = 1; k <= 1000; k++) begin
            tick();
            if (r.res_valid === 1'b1) begin
                got = k;
                break;
            end
        end
        chk("first_valid_cyc", 32'(got), 306);
        for (int i = 0; i < 500; i++) begin
            tick();
            if (i % 100 == 0) begin
                chk("stall_cs", 32'(cs), 1);
                chk("stall_valid", 32'(r.res_valid), 1);
                chk("stall_res", 32'({r.res_ch, r.res_data}),
                    32'({4'h0, fval(4'h0)}));
            end
        end
        r.res_ready = 1'b1;
        wait_done(2000, got);
        chk("bp_done_seen", 32'(got > 0), 1);
        tick();
        chk("res_left_bp", 32'(exp_res.size()), 0);
        chk("cmd_left_bp", 32'(exp_cmd.size()), 0);

        // abort and start together in idle
        ch_mask = 8'hFF;
        start   = 1'b1;
        abort   = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        chk("abst_busy", 32'(busy), 0);
        chk("abst_cs", 32'(cs), 1);

        // abort mid-scan
        frame_chk = 1'b0;
        ch_mask = 8'h05;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (59) tick();
        abort = 1'b1;
        d0 = done_cnt;
        tick();
        abort = 1'b0;
        chk("abort_cs", 32'(cs), 1);
        chk("abort_valid", 32'(r.res_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_sclk", 32'(sclk), 0);
        repeat (400) tick();
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        chk("abort_idle_cs", 32'(cs), 1);
        frame_chk = 1'b1;

        // zero mask
        d0 = done_cnt;
        ch_mask = 8'h00;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_busy", 32'(busy), 0);
        chk("zero_cs", 32'(cs), 1);
        repeat (300) tick();
        chk("zero_no_done", 32'(done_cnt), 32'(d0));
        chk("zero_cs_late", 32'(cs), 1);

        // reset mid-shift
        frame_chk = 1'b0;
        ch_mask = 8'hFF;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        chk("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        chk_reset_vals("midrst");
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_cs", 32'(cs), 1);
        chk("post_rst_busy", 32'(busy), 0);
        frame_chk = 1'b1;

        chk("res_left_end", 32'(exp_res.size()), 0);
        chk("cmd_left_end", 32'(exp_cmd.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Scan sequencer for one serial multi-channel ADC port (cs/fs/sclk/sdo/sdi/cstart) of the acquisition board. It converts a channel mask into a sequence of 16-bit command/result frames, and it compensates for the ADC's one-frame result pipeline by issuing a trailing flush frame. It delivers tagged 12-bit samples over a valid/ready handshake. Three instances sit in the 110 MHz `clk` domain, one per ADC port; a downstream packer forwards their results to the ARM over SSI.

## Interface
- `CLK_DIV`, default 4: half-period of `sclk` in `clk` cycles, range 2–255. 110 MHz gives 13.75 MHz `sclk`.
- `CONV_WAIT`, default 40: idle `clk` cycles after each frame for the ADC conversion, range 1–1023.
- `NCH`, default 8: number of channels, range 1–16. Channel index is 4 bits.
- `FLUSH_CMD`, default 4'hB: command nibble sent in the flush frame.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: one-cycle pulse that begins a scan. Ignored while `busy`=1.
- `abort`, in, 1: terminates any scan. Has priority over `start`.
- `ch_mask`, in, NCH: enabled channels. Sampled only when `start` is accepted.
- `cs`, out, 1: ADC chip select, active-low.
- `fs`, out, 1: frame sync, active-high.
- `sclk`, out, 1: serial clock.
- `sdo`, out, 1: command bit to the ADC.
- `sdi`, in, 1: data bit from the ADC.
- `cstart`, out, 1: conversion start. Held at 1; conversion is triggered by the rising edge of `cs`.
- `res_valid`, out, 1: result available.
- `res_ready`, in, 1: consumer accepts the result.
- `res_data`, out, 12: conversion result.
- `res_ch`, out, 4: channel the result belongs to.
- `busy`, out, 1: scan in progress.
- `scan_done`, out, 1: one-cycle pulse when a scan completes normally.

## Operation
- Reset values: `cs`=1, `fs`=0, `sclk`=0, `sdo`=0, `cstart`=1, `res_valid`=0, `res_data`=0, `res_ch`=0, `busy`=0, `scan_done`=0. The state machine enters IDLE.
- IDLE: accepting `start` with `ch_mask`≠0 latches the mask, selects the lowest set bit as the current channel, sets `busy`, and enters SETUP.
  - `start` with a zero mask produces no action and no `scan_done`.
- SETUP lasts `CLK_DIV` cycles, with `cs`=0, `fs`=1 and `sclk`=0. `sdo` carries command bit 15.
- SHIFT covers 16 `sclk` periods of 2·`CLK_DIV` cycles each, MSB first.
  - `sclk`=1 for the first half of each period and 0 for the second half. `fs`=0.
  - `sdo` updates at the start of each period.
  - `sdi` is captured in the last cycle of the high half.
  - Command word: {channel, 12'h000}, or {`FLUSH_CMD`, 12'h000} for the flush frame.
- HOLD lasts 1 cycle with `cs`=1. The 16-bit shift register is complete at this point.
  - Except for the first frame of a scan, it loads `res_data`=shift[15:4] and `res_ch`=channel of the previous frame's command, and sets `res_valid`.
  - The first frame's returned data is discarded.
- WAIT lasts `CONV_WAIT` cycles. The controller then moves to the next action:
  - Next set mask bit in ascending order → SETUP.
  - After the last channel → one flush frame.
  - After the flush frame's HOLD and WAIT → IDLE, pulsing `scan_done` and clearing `busy` in the same cycle.
- A scan of N enabled channels therefore runs N+1 frames and yields exactly N results, in ascending channel order.
- Backpressure: WAIT does not exit while `res_valid`=1 and `res_ready`=0, so results are never overwritten. `res_data` and `res_ch` stay stable while `res_valid`=1.
- Handshake: a transfer occurs in any cycle with `res_valid`=1 and `res_ready`=1. `res_valid` clears on the next edge unless HOLD loads a new result in that same cycle.
- `abort` in any state: on the next edge `cs`=1, `fs`=0, `sclk`=0, `sdo`=0, `res_valid`=0, `busy`=0, and the controller returns to IDLE. No `scan_done` is produced. A frame cut mid-shift is lost.
- `rst` overrides `abort`.

## Timing
- `start` accepted at edge 0 → `cs`=0 and `fs`=1 from edge 1.
- Frame length: `CLK_DIV` + 32·`CLK_DIV` + 1 cycles. Default: 133.
- First `res_valid` appears at the edge following the second frame's HOLD.
- Frame period without stall: 33·`CLK_DIV`+1+`CONV_WAIT`. Default: 173.
- A full default scan of all 8 channels takes 9·173 = 1557 cycles from the first `cs` fall to `scan_done`.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset: hold `rst` for 3 cycles mid-SHIFT → all outputs return to their reset values next cycle. `cs`=1 and `busy`=0.
- Single channel: mask 8'b0000_0100, ADC model returns 16'hABC0 in frame 2.
  - 2 frames with commands 16'h2000 then 16'hB000.
  - One result with `res_data`=12'hABC, `res_ch`=2.
  - `scan_done` at cycle 346 after `start`.
- Full scan: mask 8'hFF with `res_ready`=1.
  - 9 frames, 8 results, channels 0..7 in order, each `res_data` equal to the model value tagged for that channel.
  - `sclk` period 8 cycles; exactly 16 `sclk` pulses per `cs`-low window.
- Backpressure: mask 8'h03 with `res_ready`=0 for 500 cycles after the first `res_valid`.
  - The second frame does not begin; `cs` stays 1 and the result stays stable.
  - After release: 2 results, no loss.
- Abort/start priority:
  - `abort` and `start` in the same cycle during IDLE → stays IDLE.
  - `abort` at cycle 60 of a scan → `cs`=1 and `res_valid`=0 next cycle, with no `scan_done`.
  - `start` while `busy` → ignored.
- Zero mask: `start` with `ch_mask`=0 → `busy` stays 0, `cs` stays 1, no `scan_done`.
